// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - Shared calculator constants: queue commands, ALU opcodes, data width
package calc_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      Q_PUSH         = 2'b00,
      Q_SLEEP        = 2'b01,
      Q_GET_AND_PUSH = 2'b10,
      Q_POP          = 2'b11
   } q_op_e;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_DIV  = 3'd4,
      OP_REM  = 3'd5
   } alu_op_e;

endpackage

// File: rtl/calc_queue_mem.sv
// rtl/calc_queue_mem.sv - Queue storage: one synchronous write port, two asynchronous read ports
module calc_queue_mem
   import calc_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd0_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   input  logic [ADDR_W-1:0] rd1_addr_i,
   output logic [DATA_W-1:0] rd1_data_o
);

   // Contents are deliberately not reset; readers mask by occupancy.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd0_data_o = mem_q[rd0_addr_i];
   assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/calc_queue.sv
// rtl/calc_queue.sv - Circular byte operand queue executing ALU queue commands
module calc_queue
   import calc_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   input  logic [1:0]          queue_op,
   input  logic [DATA_W-1:0]   result,
   input  logic                calc_err,
   input  logic                err_clr,
   output logic [2*DATA_W-1:0] operands,
   output logic                operands_valid,
   output logic [ADDR_W:0]     count,
   output logic                empty,
   output logic                full,
   output logic                op_ack,
   output logic                err_ovf,
   output logic                err_udf,
   output logic                err_calc,
   output logic                err
);

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_TWO  = ADDR_W'(2);

   logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ack_q, ack_d;
   logic              ovf_q, ovf_d, udf_q, udf_d, calc_q, calc_d;
   logic              wr_en;
   logic [DATA_W-1:0] rd0_data, rd1_data;

   calc_queue_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk        (clk),
      .wr_en_i    (wr_en),
      .wr_addr_i  (tail_q),
      .wr_data_i  (result),
      .rd0_addr_i (head_q),
      .rd0_data_o (rd0_data),
      .rd1_addr_i (head_q + PTR_ONE),
      .rd1_data_o (rd1_data)
   );

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ack_d   = 1'b0;
      wr_en   = 1'b0;
      // Clear first so an error raised in the same cycle still sticks.
      ovf_d   = err_clr ? 1'b0 : ovf_q;
      udf_d   = err_clr ? 1'b0 : udf_q;
      calc_d  = err_clr ? 1'b0 : calc_q;
      if (op_valid) begin
         if (calc_err) begin
            calc_d = 1'b1;
         end else begin
            case (queue_op)
               Q_PUSH: begin
                  if (count_q == CNT_FULL) begin
                     ovf_d = 1'b1;
                  end else begin
                     wr_en   = 1'b1;
                     tail_d  = tail_q + PTR_ONE;
                     count_d = count_q + CNT_ONE;
                     ack_d   = 1'b1;
                  end
               end
               Q_POP: begin
                  if (count_q == '0) begin
                     udf_d = 1'b1;
                  end else begin
                     head_d  = head_q + PTR_ONE;
                     count_d = count_q - CNT_ONE;
                     ack_d   = 1'b1;
                  end
               end
               Q_GET_AND_PUSH: begin
                  // Net -1 entry, so this is legal even when full.
                  if (count_q < CNT_TWO) begin
                     udf_d = 1'b1;
                  end else begin
                     wr_en   = 1'b1;
                     head_d  = head_q + PTR_TWO;
                     tail_d  = tail_q + PTR_ONE;
                     count_d = count_q - CNT_ONE;
                     ack_d   = 1'b1;
                  end
               end
               default: begin
                  ack_d = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         calc_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         calc_q  <= calc_d;
      end
   end

   assign operands       = {(count_q >= CNT_TWO) ? rd1_data : {DATA_W{1'b0}},
                            (count_q != '0)      ? rd0_data : {DATA_W{1'b0}}};
   assign operands_valid = (count_q >= CNT_TWO);
   assign count          = count_q;
   assign empty          = (count_q == '0);
   assign full           = (count_q == CNT_FULL);
   assign op_ack         = ack_q;
   assign err_ovf        = ovf_q;
   assign err_udf        = udf_q;
   assign err_calc       = calc_q;
   assign err            = ovf_q | udf_q | calc_q;

endmodule

// File: tb/tb_calc_queue.sv
// tb/tb_calc_queue.sv - Randomized bench for calc_queue against a FIFO reference model
module tb_calc_queue;
   import calc_pkg::*;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [1:0]  queue_op;
   logic [7:0]  result;
   logic        calc_err;
   logic        err_clr;
   logic [15:0] operands;
   logic        operands_valid;
   logic [ADDR_W:0] count;
   logic        empty, full, op_ack, err_ovf, err_udf, err_calc, err;

   calc_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .op_valid       (op_valid),
      .queue_op       (queue_op),
      .result         (result),
      .calc_err       (calc_err),
      .err_clr        (err_clr),
      .operands       (operands),
      .operands_valid (operands_valid),
      .count          (count),
      .empty          (empty),
      .full           (full),
      .op_ack         (op_ack),
      .err_ovf        (err_ovf),
      .err_udf        (err_udf),
      .err_calc       (err_calc),
      .err            (err)
   );

   always #5 clk = ~clk;

   logic [7:0] mq[$];
   bit m_ovf, m_udf, m_calc, m_ack;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_udf = 0; m_calc = 0; m_ack = 0;
   endtask

   task automatic model_step(input bit v, input logic [1:0] op, input logic [7:0] res,
                             input bit cerr, input bit clr);
      if (clr) begin m_ovf = 0; m_udf = 0; m_calc = 0; end
      m_ack = 0;
      if (v) begin
         if (cerr) m_calc = 1;
         else if (op == Q_PUSH) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else begin mq.push_back(res); m_ack = 1; end
         end else if (op == Q_POP) begin
            if (mq.size() == 0) m_udf = 1;
            else begin void'(mq.pop_front()); m_ack = 1; end
         end else if (op == Q_GET_AND_PUSH) begin
            if (mq.size() < 2) m_udf = 1;
            else begin
               void'(mq.pop_front()); void'(mq.pop_front());
               mq.push_back(res); m_ack = 1;
            end
         end else m_ack = 1;
      end
   endtask

   task automatic check_all();
      logic [7:0] lo, hi;
      lo = (mq.size() >= 1) ? mq[0] : 8'h00;
      hi = (mq.size() >= 2) ? mq[1] : 8'h00;
      check("count",          32'(count),          32'(mq.size()));
      check("operands",       32'(operands),       32'({hi, lo}));
      check("operands_valid", 32'(operands_valid), 32'(mq.size() >= 2));
      check("empty",          32'(empty),          32'(mq.size() == 0));
      check("full",           32'(full),           32'(mq.size() == DEPTH));
      check("op_ack",         32'(op_ack),         32'(m_ack));
      check("err_ovf",        32'(err_ovf),        32'(m_ovf));
      check("err_udf",        32'(err_udf),        32'(m_udf));
      check("err_calc",       32'(err_calc),       32'(m_calc));
      check("err",            32'(err),            32'(m_ovf | m_udf | m_calc));
   endtask

   task automatic do_op(input bit v, input logic [1:0] op, input logic [7:0] res,
                        input bit cerr, input bit clr);
      op_valid = v; queue_op = op; result = res; calc_err = cerr; err_clr = clr;
      @(posedge clk);
      #1;
      op_valid = 0; calc_err = 0; err_clr = 0;
      model_step(v, op, res, cerr, clr);
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; op_valid = 0; queue_op = Q_SLEEP; result = 0; calc_err = 0; err_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) rst = 0;

      do_op(1, Q_PUSH, 8'h07, 0, 0);
      do_op(1, Q_PUSH, 8'h03, 0, 0);
      check("tp_two_operands", 32'(operands), 32'h0307);
      do_op(1, Q_GET_AND_PUSH, 8'h04, 0, 0);
      check("tp_gap_operands", 32'(operands), 32'h0004);

      do_op(1, Q_POP, 8'h00, 0, 0);
      do_op(1, Q_POP, 8'h00, 0, 0);
      check("tp_pop_empty_udf", 32'(err_udf), 32'h1);
      do_op(1, Q_PUSH, 8'h5A, 0, 0);
      do_op(1, Q_GET_AND_PUSH, 8'h11, 0, 0);
      check("tp_gap_one_count", 32'(count), 32'h1);
      do_op(0, Q_SLEEP, 8'h00, 0, 1);
      check("tp_clr_udf", 32'(err_udf), 32'h0);
      do_op(1, Q_POP, 8'h00, 0, 0);

      for (int i = 0; i < DEPTH; i++) do_op(1, Q_PUSH, 8'(i), 0, 0);
      check("tp_full", 32'(full), 32'h1);
      do_op(1, Q_PUSH, 8'hEE, 0, 0);
      check("tp_ovf_contents", 32'(operands), 32'h0100);
      do_op(1, Q_GET_AND_PUSH, 8'hAA, 0, 0);
      check("tp_gap_full", 32'(operands), 32'h0302);
      do_op(1, Q_SLEEP, 8'h00, 0, 1);

      for (int i = 0; i < 5; i++) do_op(1, Q_POP, 8'h00, 0, 0);
      for (int i = 0; i < 40; i++) begin
         do_op(1, Q_PUSH, 8'($urandom), 0, 0);
         do_op(1, Q_POP, 8'h00, 0, 0);
      end

      do_op(1, Q_GET_AND_PUSH, 8'h77, 1, 0);
      check("tp_calc_err", 32'(err), 32'h1);

      @(posedge clk);
      #3 rst = 1;
      #1 model_reset();
      check_all();
      @(negedge clk) rst = 0;

      for (int i = 0; i < 400; i++) begin
         do_op(($urandom_range(0, 9) != 0), 2'($urandom), 8'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_queue.md
Name: calc_queue

Overview:
- Byte-wide circular operand queue for the queue calculator; the consumer end of the ALU's queue_op/result interface.
- Executes queue commands (push, pop, get-and-push, sleep) issued by the ALU.
- Continuously presents the two oldest entries to the ALU as its operand word.
- Tracks occupancy and reports sticky overflow, underflow and calculation-error flags to the controller.

Parameters:
- DEPTH, 16: number of byte entries; must be a power of two, at least 4.
- ADDR_W, 4: log2(DEPTH); pointer width.
- Q_PUSH, 2'b00: command code, push result.
- Q_SLEEP, 2'b01: command code, no operation.
- Q_POP, 2'b11: command code, discard the oldest entry.
- Q_GET_AND_PUSH, 2'b10: command code, consume the two oldest entries and push result.

Ports:
- clk  in  1  Clock; rising edge.
- rst  in  1  Reset; asynchronous, active-high.
- op_valid  in  1  Strobe: queue_op, result and calc_err are sampled this cycle.
- queue_op  in  2  Command from the ALU.
- result  in  8  Byte to enqueue for Q_PUSH and Q_GET_AND_PUSH.
- calc_err  in  1  ALU divide/remainder-by-zero indication.
- err_clr  in  1  Synchronous clear of all sticky error flags.
- operands  out  16  [7:0] = oldest entry (head); [15:8] = next entry (head+1).
- operands_valid  out  1  count >= 2.
- count  out  ADDR_W+1  Current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- op_ack  out  1  One-cycle pulse, registered.
- err_ovf  out  1  Sticky: push while full.
- err_udf  out  1  Sticky: insufficient entries for a pop or get-and-push.
- err_calc  out  1  Sticky: ALU calc_err seen.
- err  out  1  OR of the three sticky flags.

Behaviour:
- Reset (async assert):
  - head, tail and count go to 0.
  - op_ack, err_ovf, err_udf and err_calc go to 0.
  - Storage array is not reset.
  - op_valid is ignored while rst is high.
- Commands are evaluated only on a rising clk edge with op_valid=1. State updates at that edge; effects are visible the next cycle. There are no multi-cycle operations.
- Priority, highest first:
  1. calc_err=1: queue unchanged, err_calc<=1, no ack.
  2. Illegal command: queue unchanged, set the relevant error flag, no ack.
  3. Otherwise execute the command and set op_ack<=1.
- Q_PUSH:
  - If full: err_ovf<=1.
  - Else: mem[tail]<=result, tail<=tail+1 mod DEPTH, count+1.
- Q_POP:
  - If empty: err_udf<=1.
  - Else: head<=head+1, count-1.
- Q_GET_AND_PUSH:
  - If count<2: err_udf<=1.
  - Else: head<=head+2, mem[tail]<=result, tail<=tail+1, count-1.
  - Legal even when full, since the net effect is -1. The write may target the slot of the consumed head; this is permitted.
- Q_SLEEP: no state change; op_ack<=1.
- op_ack: high for exactly the cycle after an accepted command; low otherwise.
- Pointers wrap modulo DEPTH. Full versus empty is distinguished by count only.
- operands is combinational from mem[head] and mem[head+1 mod DEPTH], with masking:
  - [7:0] forced to 0 when count==0.
  - [15:8] forced to 0 when count<2.
- Sticky flags:
  - Cleared by err_clr at the next edge.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
  - Errors never block later commands.
- Arithmetic: count is ADDR_W+1 bits and never leaves 0..DEPTH. No arithmetic on data bytes.

Decomposition:
- Shared package calc_pkg, used by both the ALU and this block:
  - Q_* command codes.
  - Opcode constants (PUSH..REM).
  - Data width 8.
- One natural sub-module: calc_queue_mem.
  - DEPTH x 8 storage.
  - One synchronous write port.
  - Two asynchronous read ports (head, head+1).
- Pointer, count and flag logic stays in calc_queue.

Test Plan:
- Reset, then Q_PUSH 0x07, then Q_PUSH 0x03 -> count=2, operands=16'h0307, operands_valid=1, op_ack pulses after each push.
- From that state, Q_GET_AND_PUSH with result=0x04 -> next cycle count=1, operands[7:0]=0x04, operands[15:8]=0x00, no error flags.
- On an empty queue, Q_POP -> err_udf=1, count=0, no op_ack. With count=1, Q_GET_AND_PUSH -> err_udf=1, count stays 1. err_clr -> err_udf=0.
- Push 16 bytes 0x00..0x0F -> full=1. A 17th push -> err_ovf=1, contents unchanged. Q_GET_AND_PUSH with result=0xAA while full -> count=15, operands=16'h0302.
- Wrap-around: repeat push/pop 40 times with varying data -> operands always reflects the FIFO-order model; count never exceeds 16.
- calc_err=1 with queue_op=Q_GET_AND_PUSH -> queue unchanged, err_calc=1, err=1. Assert rst mid-sequence at a non-clock edge -> outputs zero immediately, count=0.
